sa_row_skew_feeder: RTL and testbench

SA_ROW_SKEW_FEEDER -- requirements
Module: sa_row_skew_feeder

---
 rtl/sa_row_skew_feeder.sv | 109 ++++++++++
 tb/tb_sa_row_skew_feeder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_row_skew_feeder.sv
`default_nettype none
// sa_row_skew_feeder: skews each accepted beat across ROWS PE rows, row r delayed by r+1 cycles.
// Optional macro SA_FEEDER_ZERO_GATE_EN zeroes a row's out_a whenever its out_en is low.
module sa_row_skew_feeder #(
   parameter int ELEM_BITS = 8,
   parameter int ROWS      = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ROWS*ELEM_BITS-1:0] in_data,
   input  logic                      in_last,
   output logic [ROWS*ELEM_BITS-1:0] out_a,
   output logic [ROWS-1:0]           out_en,
   output logic                      busy,
   output logic                      done
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;
   logic             w_drain_end;

   assign w_accept    = in_valid && in_ready;
   assign w_drain_end = (r_state == S_DRAIN) && (r_cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_STREAM: begin
            if (w_accept) begin
               w_state_nxt = in_last ? S_DRAIN : S_STREAM;
            end
         end
         S_DRAIN: begin
            if (w_drain_end) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state != S_DRAIN);
      busy     = (r_state == S_STREAM) || (r_state == S_DRAIN);
      done     = w_drain_end;
   end

   // Drain lasts ROWS cycles: the last row needs that long to flush the final beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (w_accept && in_last) begin
         r_cnt <= CNT_W'(ROWS - 1);
      end else if ((r_state == S_DRAIN) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      logic [ELEM_BITS-1:0] r_dat [0:gr];
      logic [gr:0]          r_vld;

      // Stage 0 data only updates on acceptance, so unaccepted beats never enter the line.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_vld <= '0;
            for (int k = 0; k <= gr; k++) begin
               r_dat[k] <= '0;
            end
         end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
               r_dat[0] <= in_data[gr*ELEM_BITS +: ELEM_BITS];
            end
            for (int k = 1; k <= gr; k++) begin
               r_vld[k] <= r_vld[k-1];
               r_dat[k] <= r_dat[k-1];
            end
         end
      end

      assign out_en[gr] = r_vld[gr];
`ifdef SA_FEEDER_ZERO_GATE_EN
      assign out_a[gr*ELEM_BITS +: ELEM_BITS] = r_vld[gr] ? r_dat[gr] : '0;
`else
      assign out_a[gr*ELEM_BITS +: ELEM_BITS] = r_dat[gr];
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_sa_row_skew_feeder.sv
`default_nettype none
// tb_sa_row_skew_feeder: directed scenarios plus randomized streams checked against a beat-log model.
module tb_sa_row_skew_feeder;

   localparam int ROWS = 4;
   localparam int EB   = 8;
   localparam int W    = ROWS*EB;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_last = 1'b0;
   logic [W-1:0]    in_data = '0;
   logic            in_ready;
   logic            busy;
   logic            done;
   logic [W-1:0]    out_a;
   logic [ROWS-1:0] out_en;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: log of every post-reset edge (accepted flag + data) and a drain countdown.
   bit           acc_log[$];
   logic [W-1:0] dat_log[$];
   bit           m_stream;
   bit           m_drain;
   int           m_left;

   sa_row_skew_feeder #(.ELEM_BITS(EB), .ROWS(ROWS)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_a(out_a), .out_en(out_en),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      acc_log.delete();
      dat_log.delete();
      m_stream = 1'b0;
      m_drain  = 1'b0;
      m_left   = 0;
   endtask

   task automatic clk_step();
      bit acc;
      @(posedge clk);
      if (rstn) begin
         acc = in_valid && !m_drain;
         acc_log.push_back(acc);
         dat_log.push_back(in_data);
         if (m_drain) begin
            if (m_left == 0) m_drain = 1'b0;
            else m_left--;
         end else if (acc) begin
            if (in_last) begin
               m_drain  = 1'b1;
               m_left   = ROWS - 1;
               m_stream = 1'b0;
            end else begin
               m_stream = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [ROWS-1:0] exp_en();
      logic [ROWS-1:0] e = '0;
      int idx;
      for (int r = 0; r < ROWS; r++) begin
         idx = acc_log.size() - 1 - r;
         if (idx >= 0) e[r] = acc_log[idx];
      end
      return e;
   endfunction

   // Row r shows the newest element accepted at least r+1 edges ago.
   function automatic logic [W-1:0] exp_a();
      logic [W-1:0] a = '0;
      logic [W-1:0] beat;
      logic [ROWS-1:0] en;
      int idx;
      en = exp_en();
      for (int r = 0; r < ROWS; r++) begin
         idx = acc_log.size() - 1 - r;
         for (int j = idx; j >= 0; j--) begin
            if (acc_log[j]) begin
               beat = dat_log[j];
               a[r*EB +: EB] = beat[r*EB +: EB];
               break;
            end
         end
`ifdef SA_FEEDER_ZERO_GATE_EN
         if (!en[r]) a[r*EB +: EB] = '0;
`endif
      end
      return a;
   endfunction

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < n; i++) clk_step();
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 32'hDEADBEEF;
      clk_step();
      clk_step();
      n_checks++;
      if ({out_a, out_en, done, busy, in_ready} !== {{W{1'b0}}, {ROWS{1'b0}}, 3'b001}) begin
         n_errors++;
         $display("FAIL reset_outputs: got a=%h en=%b done=%b busy=%b rdy=%b, want all zero rdy=1",
                  out_a, out_en, done, busy, in_ready);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      rstn     = 1'b1;
      model_reset();
      clk_step();
   endtask

   task automatic test_single_beat();
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 32'h04030201;
      clk_step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         n_checks++;
         if (out_en !== ((c <= 4) ? 4'(1 << (c-1)) : 4'b0)) begin
            n_errors++;
            $display("FAIL single_en cycle %0d: got %b", c, out_en);
         end
         if (c <= 4) begin
            n_checks++;
            if (out_a[(c-1)*EB +: EB] !== 8'(c)) begin
               n_errors++;
               $display("FAIL single_data cycle %0d: got %h want %h", c, out_a[(c-1)*EB +: EB], c);
            end
         end
         n_checks++;
         if (done !== (c == 4)) begin
            n_errors++;
            $display("FAIL single_done cycle %0d: got %b want %b", c, done, c == 4);
         end
         n_checks++;
         if (in_ready !== (c == 5) || busy !== (c <= 4)) begin
            n_errors++;
            $display("FAIL single_ready_busy cycle %0d: got rdy=%b busy=%b", c, in_ready, busy);
         end
         clk_step();
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      in_data  = 32'h11111111;
      in_last  = 1'b0;
      clk_step();
      in_data  = 32'h22222222;
      clk_step();
      in_data  = 32'h33333333;
      in_last  = 1'b1;
      clk_step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int c = 3; c <= 7; c++) begin
         n_checks++;
         if (out_en[3] !== (c >= 4 && c <= 6)) begin
            n_errors++;
            $display("FAIL b2b_row3_en cycle %0d: got %b", c, out_en[3]);
         end
         if (c >= 4 && c <= 6) begin
            n_checks++;
            if (out_a[3*EB +: EB] !== 8'(17*(c-3))) begin
               n_errors++;
               $display("FAIL b2b_row3_data cycle %0d: got %h want %h", c, out_a[3*EB +: EB], 17*(c-3));
            end
         end
         n_checks++;
         if (done !== (c == 6)) begin
            n_errors++;
            $display("FAIL b2b_done cycle %0d: got %b want %b", c, done, c == 6);
         end
         clk_step();
      end
   endtask

   task automatic test_bubble();
      logic [W-1:0] d0, d2;
      d0 = {$urandom};
      d2 = {$urandom};
      in_valid = 1'b1; in_last = 1'b0; in_data = d0;
      clk_step();
      in_valid = 1'b0; in_data = 32'hFFFFFFFF;
      clk_step();
      in_valid = 1'b1; in_last = 1'b1; in_data = d2;
      clk_step();
      in_valid = 1'b0; in_last = 1'b0;
      for (int c = 3; c <= 7; c++) begin
         n_checks++;
         if (out_en[2] !== (c == 3 || c == 5)) begin
            n_errors++;
            $display("FAIL bubble_row2_en cycle %0d: got %b", c, out_en[2]);
         end
         if (c == 3 || c == 5) begin
            n_checks++;
            if (out_a[2*EB +: EB] !== ((c == 3) ? d0[2*EB +: EB] : d2[2*EB +: EB])) begin
               n_errors++;
               $display("FAIL bubble_row2_data cycle %0d: got %h", c, out_a[2*EB +: EB]);
            end
         end
`ifdef SA_FEEDER_ZERO_GATE_EN
         if (c == 4) begin
            n_checks++;
            if (out_a[2*EB +: EB] !== 8'h00) begin
               n_errors++;
               $display("FAIL bubble_gate cycle 4: got %h want 00", out_a[2*EB +: EB]);
            end
         end
`endif
         n_checks++;
         if (done !== (c == 6)) begin
            n_errors++;
            $display("FAIL bubble_done cycle %0d: got %b", c, done);
         end
         clk_step();
      end
   endtask

   task automatic test_drain_ignore();
      in_valid = 1'b1; in_last = 1'b1; in_data = 32'h0A0B0C0D;
      clk_step();
      in_last = 1'b0;
      in_data = 32'hFFFFFFFF;
      for (int c = 1; c <= 8; c++) begin
         n_checks++;
         for (int r = 0; r < ROWS; r++) begin
            if (out_a[r*EB +: EB] === 8'hFF) begin
               n_errors++;
               $display("FAIL drain_ff_leak cycle %0d row %0d: got ff", c, r);
               break;
            end
         end
         n_checks++;
         if (in_ready !== (c > 4)) begin
            n_errors++;
            $display("FAIL drain_ready cycle %0d: got %b want %b", c, in_ready, c > 4);
         end
         in_valid = (c < 4);
         clk_step();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1; in_last = 1'b0;
      in_data = 32'h55555555;
      clk_step();
      in_data = 32'h66666666;
      clk_step();
      rstn = 1'b0;
      in_valid = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({out_a, out_en, done, busy, in_ready} !== {{W{1'b0}}, {ROWS{1'b0}}, 3'b001}) begin
         n_errors++;
         $display("FAIL midreset_outputs: got a=%h en=%b done=%b busy=%b rdy=%b",
                  out_a, out_en, done, busy, in_ready);
      end
      clk_step();
      rstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if (done !== 1'b0 || out_en !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_residue cycle %0d: got done=%b en=%b busy=%b", c, done, out_en, busy);
         end
         clk_step();
      end
      test_single_beat();
   endtask

   task automatic test_last_no_valid();
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = {$urandom};
      for (int c = 0; c < 4; c++) begin
         clk_step();
         n_checks++;
         if (busy !== 1'b0 || in_ready !== 1'b1 || out_en !== '0) begin
            n_errors++;
            $display("FAIL last_no_valid cycle %0d: got busy=%b rdy=%b en=%b", c, busy, in_ready, out_en);
         end
      end
      in_last = 1'b0;
   endtask

   task automatic test_random();
      logic [ROWS-1:0] e_en;
      logic [W-1:0]    e_a;
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_last  = ($urandom_range(0, 9) == 0);
         in_data  = {$urandom};
         clk_step();
         e_en = exp_en();
         e_a  = exp_a();
         n_checks++;
         if (out_en !== e_en) begin
            n_errors++;
            $display("FAIL rand_en step %0d: got %b want %b", i, out_en, e_en);
         end
         n_checks++;
         if (out_a !== e_a) begin
            n_errors++;
            $display("FAIL rand_data step %0d: got %h want %h", i, out_a, e_a);
         end
         n_checks++;
         if (done !== (m_drain && m_left == 0)) begin
            n_errors++;
            $display("FAIL rand_done step %0d: got %b want %b", i, done, m_drain && m_left == 0);
         end
         n_checks++;
         if (busy !== (m_stream || m_drain) || in_ready !== !m_drain) begin
            n_errors++;
            $display("FAIL rand_busy_ready step %0d: got busy=%b rdy=%b want busy=%b rdy=%b",
                     i, busy, in_ready, m_stream || m_drain, !m_drain);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_beat();
      idle_cycles(3);
      test_back_to_back();
      idle_cycles(3);
      test_bubble();
      idle_cycles(3);
      test_drain_ignore();
      idle_cycles(3);
      test_reset_midstream();
      idle_cycles(3);
      test_last_no_valid();
      test_random();
      idle_cycles(6);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
